// File: rtl/player_life_pkg.sv
// Purpose: shared types for the per-player survival tracker.
// Latency: n/a (types only).
// Backpressure: n/a.
package player_life_pkg;

  // Per-player lifecycle. IDLE marks a non-participating (or not yet started) player.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIVE  = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } pl_state_e;

endpackage

// File: rtl/player_life_fsm.sv
// Purpose: one player channel: bounds/obstacle hit check, lives counter, invulnerability window, death latch.
// Latency: frame_tick in cycle N -> state/lives/hit pulse visible in cycle N+1.
// Backpressure: none; evaluation happens only on frame_tick, otherwise everything holds.
// Ports: clk/reset (sync, active-low); frame_tick_i, start_i, in_game_i, height_i, pipe_hit_i in;
//        state_d_o (next state, for the game-over reduction), is_dead_o, invuln_o, hit_pulse_o, lives_o out.
module player_life_fsm
  import player_life_pkg::*;
#(
  parameter int HEIGHT_W      = 9,
  parameter int TOP_LIMIT     = 10,
  parameter int BOTTOM_LIMIT  = 420,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int LIVES_W       = $clog2(LIVES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick_i,
  input  logic                start_i,
  input  logic                in_game_i,
  input  logic [HEIGHT_W-1:0] height_i,
  input  logic                pipe_hit_i,
  output pl_state_e           state_d_o,
  output logic                is_dead_o,
  output logic                invuln_o,
  output logic                hit_pulse_o,
  output logic [LIVES_W-1:0]  lives_o
);

  localparam int CNT_W = $clog2(INVULN_FRAMES + 1);

  pl_state_e          state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hit_q, hit_d;
  logic               hit;

  // The limits themselves are safe; only strictly outside is a hit.
  assign hit = (height_i < HEIGHT_W'(TOP_LIMIT)) ||
               (height_i > HEIGHT_W'(BOTTOM_LIMIT)) ||
               pipe_hit_i;

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    // start wins over a coincident tick: reload without evaluating hits.
    if (start_i) begin
      cnt_d = '0;
      if (in_game_i) begin
        state_d = ALIVE;
        lives_d = LIVES_W'(LIVES);
      end else begin
        state_d = IDLE;
        lives_d = '0;
      end
    end else if (frame_tick_i) begin
      case (state_q)
        ALIVE: begin
          if (hit) begin
            hit_d = 1'b1;
            if (lives_q > LIVES_W'(1)) begin
              lives_d = lives_q - LIVES_W'(1);
              cnt_d   = CNT_W'(INVULN_FRAMES);
              state_d = INVULN;
            end else begin
              lives_d = '0;
              state_d = DEAD;
            end
          end
        end
        INVULN: begin
          // Hits ignored; the tick that empties the counter returns to ALIVE,
          // so the next tick is the first one evaluated again.
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ALIVE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      lives_q <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
    end
  end

  assign state_d_o   = state_d;
  assign is_dead_o   = (state_q == DEAD);
  assign invuln_o    = (state_q == INVULN);
  assign hit_pulse_o = hit_q;
  assign lives_o     = lives_q;

endmodule

// File: rtl/player_life_monitor.sv
// Purpose: multi-player survival tracker; one life channel per player plus the game-over reduction.
// Latency: frame_tick/start in cycle N -> all outputs (incl. game_over) updated in cycle N+1.
// Backpressure: none; inputs sampled on frame_tick/start, outputs are registered levels/pulses.
// Ports: clk/reset (sync, active-low); frame_tick, start, in_game[P], height[P*HEIGHT_W], pipe_hit[P] in;
//        is_dead[P], invuln[P], hit_pulse[P], lives_left[P*LIVES_W], game_over out. Player 0 in LSBs.
module player_life_monitor
  import player_life_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int HEIGHT_W      = 9,
  parameter int TOP_LIMIT     = 10,
  parameter int BOTTOM_LIMIT  = 420,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60,
  localparam int LIVES_W      = $clog2(LIVES + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            frame_tick,
  input  logic                            start,
  input  logic [NUM_PLAYERS-1:0]          in_game,
  input  logic [NUM_PLAYERS*HEIGHT_W-1:0] height,
  input  logic [NUM_PLAYERS-1:0]          pipe_hit,
  output logic [NUM_PLAYERS-1:0]          is_dead,
  output logic [NUM_PLAYERS-1:0]          invuln,
  output logic [NUM_PLAYERS-1:0]          hit_pulse,
  output logic [NUM_PLAYERS*LIVES_W-1:0]  lives_left,
  output logic                            game_over
);

  pl_state_e st_d [NUM_PLAYERS];
  logic      game_over_q, game_over_d;

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_ch
    player_life_fsm #(
      .HEIGHT_W      (HEIGHT_W),
      .TOP_LIMIT     (TOP_LIMIT),
      .BOTTOM_LIMIT  (BOTTOM_LIMIT),
      .LIVES         (LIVES),
      .INVULN_FRAMES (INVULN_FRAMES),
      .LIVES_W       (LIVES_W)
    ) u_fsm (
      .clk          (clk),
      .reset        (reset),
      .frame_tick_i (frame_tick),
      .start_i      (start),
      .in_game_i    (in_game[i]),
      .height_i     (height[i*HEIGHT_W +: HEIGHT_W]),
      .pipe_hit_i   (pipe_hit[i]),
      .state_d_o    (st_d[i]),
      .is_dead_o    (is_dead[i]),
      .invuln_o     (invuln[i]),
      .hit_pulse_o  (hit_pulse[i]),
      .lives_o      (lives_left[i*LIVES_W +: LIVES_W])
    );
  end

  // Reduce over next-state so game_over lines up with is_dead in the same cycle.
  // Non-IDLE players are the participants; need at least one, and all of them DEAD.
  always_comb begin
    logic any_part;
    logic all_dead;
    any_part = 1'b0;
    all_dead = 1'b1;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (st_d[i] != IDLE) begin
        any_part = 1'b1;
        if (st_d[i] != DEAD) all_dead = 1'b0;
      end
    end
    game_over_d = any_part && all_dead;
  end

  always_ff @(posedge clk) begin
    if (!reset) game_over_q <= 1'b0;
    else        game_over_q <= game_over_d;
  end

  assign game_over = game_over_q;

endmodule

// File: tb/tb_player_life_monitor.sv
module tb_player_life_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        start;
  logic [1:0]  in_game;
  logic [17:0] height;
  logic [1:0]  pipe_hit;
  logic [1:0]  is_dead;
  logic [1:0]  invuln;
  logic [1:0]  hit_pulse;
  logic [3:0]  lives_left;
  logic        game_over;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  player_life_monitor #(
    .NUM_PLAYERS   (2),
    .HEIGHT_W      (9),
    .TOP_LIMIT     (10),
    .BOTTOM_LIMIT  (420),
    .LIVES         (3),
    .INVULN_FRAMES (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start      (start),
    .in_game    (in_game),
    .height     (height),
    .pipe_hit   (pipe_hit),
    .is_dead    (is_dead),
    .invuln     (invuln),
    .hit_pulse  (hit_pulse),
    .lives_left (lives_left),
    .game_over  (game_over)
  );

  // Stimulus drivers: inputs change 1ns after the rising edge, outputs are read there too.
  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] ig);
    in_game = ig;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic set_heights(input logic [8:0] h0, input logic [8:0] h1);
    height = {h1, h0};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_cycle();
    idle_cycle();
    n_cmp++; if (is_dead !== 2'b00) begin n_err++; $display("FAIL reset_is_dead: got %b want 00", is_dead); end
    n_cmp++; if (invuln !== 2'b00) begin n_err++; $display("FAIL reset_invuln: got %b want 00", invuln); end
    n_cmp++; if (hit_pulse !== 2'b00) begin n_err++; $display("FAIL reset_hit: got %b want 00", hit_pulse); end
    n_cmp++; if (lives_left !== 4'h0) begin n_err++; $display("FAIL reset_lives: got %h want 0", lives_left); end
    n_cmp++; if (game_over !== 1'b0) begin n_err++; $display("FAIL reset_game_over: got %b want 0", game_over); end
    reset = 1'b1;
    idle_cycle();
    // A start with nobody participating never produces game_over.
    do_start(2'b00);
    n_cmp++; if (game_over !== 1'b0) begin n_err++; $display("FAIL empty_game_over: got %b want 0", game_over); end
  endtask

  task automatic test_start();
    set_heights(9'd200, 9'd200);
    do_start(2'b11);
    n_cmp++; if (lives_left !== 4'hF) begin n_err++; $display("FAIL start_lives: got %h want f", lives_left); end
    n_cmp++; if (is_dead !== 2'b00) begin n_err++; $display("FAIL start_is_dead: got %b want 00", is_dead); end
    n_cmp++; if (invuln !== 2'b00) begin n_err++; $display("FAIL start_invuln: got %b want 00", invuln); end
    n_cmp++; if (game_over !== 1'b0) begin n_err++; $display("FAIL start_game_over: got %b want 0", game_over); end
  endtask

  task automatic test_bounds();
    set_heights(9'd10, 9'd420);
    do_tick();
    n_cmp++; if (hit_pulse !== 2'b00) begin n_err++; $display("FAIL edge_heights_hit: got %b want 00", hit_pulse); end
    n_cmp++; if (lives_left !== 4'hF) begin n_err++; $display("FAIL edge_heights_lives: got %h want f", lives_left); end
    set_heights(9'd9, 9'd200);
    do_tick();
    set_heights(9'd200, 9'd200);
    n_cmp++; if (hit_pulse !== 2'b01) begin n_err++; $display("FAIL low_hit_pulse: got %b want 01", hit_pulse); end
    n_cmp++; if (lives_left !== 4'hE) begin n_err++; $display("FAIL low_hit_lives: got %h want e", lives_left); end
    n_cmp++; if (invuln !== 2'b01) begin n_err++; $display("FAIL low_hit_invuln: got %b want 01", invuln); end
    idle_cycle();
    n_cmp++; if (hit_pulse !== 2'b00) begin n_err++; $display("FAIL hit_pulse_width: got %b want 00", hit_pulse); end
    n_cmp++; if (lives_left !== 4'hE) begin n_err++; $display("FAIL hold_no_tick: got %h want e", lives_left); end
  endtask

  // P0 held at 421: hits on ticks 1, 6, 11 (4 ignored ticks each), death on 11.
  task automatic test_invuln_window();
    logic [1:0] exp_hit;
    logic       exp_inv;
    logic [1:0] exp_lives;
    int         nhits;
    set_heights(9'd200, 9'd200);
    do_start(2'b11);
    set_heights(9'd421, 9'd200);
    nhits = 0;
    for (int t = 1; t <= 11; t++) begin
      do_tick();
      exp_hit   = ((t % 5) == 1) ? 2'b01 : 2'b00;
      if (exp_hit[0]) nhits++;
      exp_inv   = ((t % 5) != 0) && (t < 11);
      exp_lives = 2'(3 - nhits);
      n_cmp++; if (hit_pulse !== exp_hit) begin n_err++; $display("FAIL window_hit t=%0d: got %b want %b", t, hit_pulse, exp_hit); end
      n_cmp++; if (invuln[0] !== exp_inv) begin n_err++; $display("FAIL window_invuln t=%0d: got %b want %b", t, invuln[0], exp_inv); end
      n_cmp++; if (lives_left[1:0] !== exp_lives) begin n_err++; $display("FAIL window_lives t=%0d: got %0d want %0d", t, lives_left[1:0], exp_lives); end
      idle_cycle();
    end
    n_cmp++; if (is_dead !== 2'b01) begin n_err++; $display("FAIL window_dead: got %b want 01", is_dead); end
    n_cmp++; if (lives_left !== 4'hC) begin n_err++; $display("FAIL window_final_lives: got %h want c", lives_left); end
    n_cmp++; if (game_over !== 1'b0) begin n_err++; $display("FAIL window_game_over: got %b want 0", game_over); end
  endtask

  task automatic test_game_over();
    set_heights(9'd200, 9'd200);
    do_start(2'b01);
    n_cmp++; if (lives_left !== 4'h3) begin n_err++; $display("FAIL solo_start_lives: got %h want 3", lives_left); end
    set_heights(9'd421, 9'd5);
    for (int t = 1; t <= 10; t++) begin
      do_tick();
    end
    n_cmp++; if (game_over !== 1'b0) begin n_err++; $display("FAIL pre_fatal_game_over: got %b want 0", game_over); end
    do_tick();
    n_cmp++; if (game_over !== 1'b1) begin n_err++; $display("FAIL fatal_game_over: got %b want 1", game_over); end
    n_cmp++; if (is_dead !== 2'b01) begin n_err++; $display("FAIL fatal_is_dead: got %b want 01", is_dead); end
    n_cmp++; if (hit_pulse !== 2'b01) begin n_err++; $display("FAIL fatal_hit: got %b want 01", hit_pulse); end
    n_cmp++; if (lives_left !== 4'h0) begin n_err++; $display("FAIL fatal_lives: got %h want 0", lives_left); end
    do_tick();
    n_cmp++; if (game_over !== 1'b1) begin n_err++; $display("FAIL dead_hold_game_over: got %b want 1", game_over); end
    n_cmp++; if (hit_pulse !== 2'b00) begin n_err++; $display("FAIL dead_no_hit: got %b want 00", hit_pulse); end
  endtask

  task automatic test_back_to_back();
    set_heights(9'd200, 9'd200);
    do_start(2'b11);
    pipe_hit = 2'b11;
    do_tick();
    n_cmp++; if (hit_pulse !== 2'b11) begin n_err++; $display("FAIL dual_hit: got %b want 11", hit_pulse); end
    n_cmp++; if (lives_left !== 4'hA) begin n_err++; $display("FAIL dual_lives: got %h want a", lives_left); end
    n_cmp++; if (invuln !== 2'b11) begin n_err++; $display("FAIL dual_invuln: got %b want 11", invuln); end
    // start together with a tick reloads and skips evaluation.
    frame_tick = 1'b1;
    do_start(2'b11);
    frame_tick = 1'b0;
    n_cmp++; if (lives_left !== 4'hF) begin n_err++; $display("FAIL start_tick_lives: got %h want f", lives_left); end
    n_cmp++; if (hit_pulse !== 2'b00) begin n_err++; $display("FAIL start_tick_hit: got %b want 00", hit_pulse); end
    n_cmp++; if (invuln !== 2'b00) begin n_err++; $display("FAIL start_tick_invuln: got %b want 00", invuln); end
  endtask

  task automatic test_reset_mid_invuln();
    do_tick();
    n_cmp++; if (invuln !== 2'b11) begin n_err++; $display("FAIL pre_reset_invuln: got %b want 11", invuln); end
    reset      = 1'b0;
    frame_tick = 1'b1;
    start      = 1'b1;
    idle_cycle();
    frame_tick = 1'b0;
    start      = 1'b0;
    reset      = 1'b1;
    n_cmp++; if ({is_dead, invuln, hit_pulse, lives_left, game_over} !== 11'd0) begin
      n_err++; $display("FAIL mid_invuln_reset: got %b want all zero", {is_dead, invuln, hit_pulse, lives_left, game_over});
    end
    set_heights(9'd0, 9'd500);
    for (int t = 0; t < 3; t++) begin
      do_tick();
      n_cmp++; if ({is_dead, invuln, hit_pulse, lives_left, game_over} !== 11'd0) begin
        n_err++; $display("FAIL idle_tick_%0d: got %b want all zero", t, {is_dead, invuln, hit_pulse, lives_left, game_over});
      end
    end
  endtask

  initial begin
    reset      = 1'b0;
    frame_tick = 1'b0;
    start      = 1'b0;
    in_game    = 2'b00;
    pipe_hit   = 2'b00;
    height     = '0;
    #1;
    test_reset();
    test_start();
    test_bounds();
    test_invuln_window();
    test_game_over();
    test_back_to_back();
    test_reset_mid_invuln();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/player_life_monitor.md
# player_life_monitor

Multi-player survival tracker for the game core; replaces the single-player combinational dead check. Per player, samples bird height and an external obstacle-collision flag once per frame, and manages a lives counter, a post-hit invulnerability window and a latched death state. Sits between the physics/height update logic and the score/display/game-state controller, which consumes `is_dead`, `lives_left` and `game_over`.

## Interface
- `NUM_PLAYERS`, 2, number of independent player channels
- `HEIGHT_W`, 9, bits per player height
- `TOP_LIMIT`, 10, heights strictly below this are out of bounds
- `BOTTOM_LIMIT`, 420, heights strictly above this are out of bounds
- `LIVES`, 3, lives loaded at game start (≥1)
- `INVULN_FRAMES`, 60, frames of invulnerability after a non-fatal hit (≥1)

- `clk`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-low
- `frame_tick`  in  1  one-cycle pulse per video frame; all evaluation gated by it
- `start`  in  1  one-cycle pulse, begins a game
- `in_game`  in  NUM_PLAYERS  per-player participation, sampled on `start`
- `height`  in  NUM_PLAYERS*HEIGHT_W  packed heights, player 0 in LSBs
- `pipe_hit`  in  NUM_PLAYERS  per-player obstacle overlap, level, sampled on `frame_tick`
- `is_dead`  out  NUM_PLAYERS  player in DEAD
- `invuln`  out  NUM_PLAYERS  player in INVULN
- `hit_pulse`  out  NUM_PLAYERS  one-cycle pulse per registered hit
- `lives_left`  out  NUM_PLAYERS*LIVES_W  packed lives, LIVES_W = $clog2(LIVES+1)
- `game_over`  out  1  every participating player is DEAD

## Operation
- Per-player FSM, states IDLE, ALIVE, INVULN, DEAD.
- hit condition (per player) = `height < TOP_LIMIT` or `height > BOTTOM_LIMIT` or `pipe_hit`; 10 and 420 themselves are safe.
- `start`: players with `in_game`=1 → ALIVE, lives = LIVES, invuln counter 0; players with `in_game`=0 → IDLE, lives 0. `start` overrides `frame_tick` in the same cycle (no hit evaluation that cycle).
- On `frame_tick` only:
  - ALIVE, hit, lives>1: lives−1, counter = INVULN_FRAMES, → INVULN, `hit_pulse`.
  - ALIVE, hit, lives==1: lives → 0, → DEAD, `hit_pulse`.
  - INVULN: hits ignored; counter−1; when counter reaches 0 (i.e. tick with counter==1) → ALIVE. Hit evaluated again from the following tick.
  - DEAD, IDLE: hold until `start` or reset.
- Without `frame_tick`, all state, counters and lives hold; `hit_pulse` low.
- `game_over` = (≥1 participating player) and all participating players DEAD; 0 when no game started.
- Channels fully independent; simultaneous hits on several players each processed the same tick.

## Timing
- All outputs registered. Tick in cycle N → state/lives/`hit_pulse` visible in cycle N+1; `game_over` also valid in cycle N+1 (derived from next-state, registered).
- `hit_pulse` high exactly one cycle per hit.
- Invulnerability spans exactly INVULN_FRAMES ticks: hit on tick k, ticks k+1..k+INVULN_FRAMES ignore hits, tick k+INVULN_FRAMES+1 is first evaluated.
- Reset (reset=0 at clock edge), any state incl. mid-INVULN: all players IDLE, `is_dead`=0, `invuln`=0, `hit_pulse`=0, `lives_left`=0, counters 0, `game_over`=0. Reset overrides `start` and `frame_tick`.
- `start` while a game is running restarts immediately (re-sample `in_game`).

## Structure
- `player_life_pkg`: state enum (IDLE, ALIVE, INVULN, DEAD).
- Sub-module `player_life_fsm`: one channel (FSM, lives counter, invuln counter, bounds compare), instantiated NUM_PLAYERS times in a generate loop; top handles unpacking and `game_over` reduction.
- Counter width $clog2(INVULN_FRAMES+1), derived locally.

## Test plan
- Reset then `start` with in_game=2'b11, heights 200 → both ALIVE, lives_left 3/3, is_dead=0, game_over=0.
- P0 height 9 on one tick → next cycle hit_pulse[0]=1 one cycle, lives 2, invuln[0]=1; P1 unaffected; heights 10 and 420 produce no hit.
- P0 held out of bounds (height 421) continuously, INVULN_FRAMES=4 → exactly one hit per 5 ticks; after third hit is_dead[0]=1, lives 0.
- in_game=2'b01, P0 killed → game_over=1 one cycle after fatal tick; P1 remains IDLE, lives 0.
- Simultaneous `pipe_hit`=2'b11 on same tick → both lose a life, both hit_pulse high same cycle; `start` coincident with tick → lives reload, no decrement.
- Reset asserted mid-INVULN → next cycle all outputs zero; `frame_tick` pulses without `start` cause no change.
